// File: rtl/uart_lite_pkg.sv
// Shared definitions for the uart_lite peripheral: register offsets, bit positions and FSM encodings.
package uart_lite_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_RXDATA = 2'd1;
    localparam logic [1:0] UART_STATUS = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    localparam int unsigned ST_TX_BUSY    = 0;
    localparam int unsigned ST_RX_VALID   = 1;
    localparam int unsigned ST_RX_OVERRUN = 2;
    localparam int unsigned ST_FRAME_ERR  = 3;

    localparam int unsigned CTRL_TX_INT_EN = 0;
    localparam int unsigned CTRL_RX_INT_EN = 1;
    localparam int unsigned CTRL_LOOPBACK  = 2;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Bit-period counter width; covers CLK_DIV up to 65535.
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        UART_S_IDLE  = 2'd0,
        UART_S_START = 2'd1,
        UART_S_DATA  = 2'd2,
        UART_S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_lite_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle byte_valid pulse.
module uart_lite_rx
    import uart_lite_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

    uart_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             sync1;
    logic             sync2;

    assign rx_data = shreg;

    // After the half-bit start check, every later sample lands at mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            state      <= UART_S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rxd;
            sync2      <= sync1;
            byte_valid <= 1'b0;
            case (state)
                UART_S_IDLE: begin
                    cnt <= '0;
                    if (!sync2) state <= UART_S_START;
                end
                UART_S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync2 ? UART_S_IDLE : UART_S_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                UART_S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= UART_S_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                UART_S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        frame_err  <= ~sync2;
                        byte_valid <= 1'b1;
                        state      <= UART_S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= UART_S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_lite.sv
// Memory-mapped 8N1 UART: TX shifter, RX holding register, status/ctrl and level interrupt.
// Optional UART_LOOPBACK_EN adds CTRL[2] to route TX internally into RX and hold txd_o idle.
module uart_lite
    import uart_lite_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        uart_int_o,
    output logic        txd_o,
    input  logic        rxd_i
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);

    logic [1:0] reg_addr;
    logic       wr;
    logic       rd;
    logic       wr_status;
    logic       rd_rx;
    logic       tx_start;
    logic       tx_busy;
    logic       unused_bits;

    assign reg_addr    = addr_i[3:2];
    assign wr          = ce_i & we_i & sel_i[0];
    assign rd          = ce_i & ~we_i;
    assign wr_status   = wr & (reg_addr == UART_STATUS);
    assign rd_rx       = rd & (reg_addr == UART_RXDATA);
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], sel_i[3:1], data_i[31:8]};

    // Transmitter state
    uart_state_e      tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shreg;
    logic             tx_line;
    logic             tx_next;
    logic             loopback;

    assign tx_busy  = (tx_state != UART_S_IDLE);
    assign tx_start = wr & (reg_addr == UART_TXDATA) & ~tx_busy;

    // Serial level for the next cycle, shared by the internal line and the pin.
    always_comb begin
        tx_next = tx_line;
        case (tx_state)
            UART_S_IDLE:  if (tx_start) tx_next = 1'b0;
            UART_S_START: if (tx_cnt == BIT_LAST) tx_next = tx_shreg[0];
            UART_S_DATA: begin
                if (tx_cnt == BIT_LAST)
                    tx_next = (tx_bit == 3'd7) ? UART_IDLE_LEVEL : tx_shreg[tx_bit + 3'd1];
            end
            default: tx_next = tx_line;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= UART_S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_line  <= UART_IDLE_LEVEL;
            txd_o    <= UART_IDLE_LEVEL;
        end else begin
            tx_line <= tx_next;
            txd_o   <= loopback ? UART_IDLE_LEVEL : tx_next;
            case (tx_state)
                UART_S_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (tx_start) begin
                        tx_shreg <= data_i[7:0];
                        tx_state <= UART_S_START;
                    end
                end
                UART_S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= UART_S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                UART_S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) tx_state <= UART_S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                UART_S_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= UART_S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= UART_S_IDLE;
            endcase
        end
    end

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge clk) begin
        if (rst) loopback <= 1'b0;
        else if (wr && reg_addr == UART_CTRL) loopback <= data_i[CTRL_LOOPBACK];
    end
`else
    assign loopback = 1'b0;
`endif

    // Receiver
    logic       rx_line;
    logic       rx_byte_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    assign rx_line = loopback ? tx_line : rxd_i;

    uart_lite_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rx_line),
        .byte_valid (rx_byte_valid),
        .rx_data    (rx_data),
        .frame_err  (rx_ferr)
    );

    // Registers; clears are written before sets so a same-cycle error event wins.
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_overrun;
    logic       frame_err;
    logic       tx_int_en;
    logic       rx_int_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_int_en  <= 1'b0;
            rx_int_en  <= 1'b0;
            uart_int_o <= 1'b0;
        end else begin
            if (wr && reg_addr == UART_CTRL) begin
                tx_int_en <= data_i[CTRL_TX_INT_EN];
                rx_int_en <= data_i[CTRL_RX_INT_EN];
            end
            if (wr_status && data_i[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
            if (wr_status && data_i[ST_FRAME_ERR])  frame_err  <= 1'b0;
            if (rx_byte_valid) begin
                if (!rx_valid || rd_rx) begin
                    rx_byte  <= rx_data;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
                if (rx_ferr) frame_err <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            uart_int_o <= (rx_int_en & rx_valid) | (tx_int_en & ~tx_busy);
        end
    end

    // Read mux
    always_comb begin
        data_o = '0;
        if (ce_i && !we_i) begin
            case (reg_addr)
                UART_RXDATA: data_o = {24'd0, rx_byte};
                UART_STATUS: begin
                    data_o[ST_TX_BUSY]    = tx_busy;
                    data_o[ST_RX_VALID]   = rx_valid;
                    data_o[ST_RX_OVERRUN] = rx_overrun;
                    data_o[ST_FRAME_ERR]  = frame_err;
                end
                UART_CTRL: begin
                    data_o[CTRL_TX_INT_EN] = tx_int_en;
                    data_o[CTRL_RX_INT_EN] = rx_int_en;
                    data_o[CTRL_LOOPBACK]  = loopback;
                end
                default: data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_lite.sv
// Directed bench for uart_lite with CLK_DIV=16: register table plus TX/RX frame sequences.
`timescale 1ns/1ps
module tb_uart_lite;

    localparam int unsigned DIV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic        txd;
    logic        rxd = 1'b1;

    int tests = 0;
    int fails = 0;
    logic [31:0] got;
    logic [31:0] got_fork;

    always #5 clk = ~clk;

    uart_lite #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce),
        .we_i       (we),
        .addr_i     (addr),
        .sel_i      (sel),
        .data_i     (wdata),
        .data_o     (rdata),
        .uart_int_o (irq),
        .txd_o      (txd),
        .rxd_i      (rxd)
    );

    typedef struct {
        string       name;
        logic        is_read;
        logic [3:0]  sel;
        logic [1:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_int;
    } vec_t;

    vec_t vecs[12];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
        ce = 1'b1; we = 1'b1; addr = {28'd0, idx, 2'b00}; sel = s; wdata = d;
        tick(1);
        ce = 1'b0; we = 1'b0; sel = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] idx, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = {28'd0, idx, 2'b00};
        #1 d = rdata;
        tick(1);
        ce = 1'b0;
    endtask

    // Looks at a register combinationally without crossing a clock edge.
    task automatic peek(input logic [1:0] idx, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = {28'd0, idx, 2'b00};
        #1 d = rdata;
        ce = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(DIV);
        end
        rxd = stop;
        tick(stop_len);
        rxd = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        int lows;

        vecs[0]  = '{"rd_status_rst",  1'b1, 4'h0, 2'd2, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{"rd_ctrl_rst",    1'b1, 4'h0, 2'd3, 32'h0, 32'h0, 1'b0};
        vecs[2]  = '{"rd_txdata",      1'b1, 4'h0, 2'd0, 32'h0, 32'h0, 1'b0};
        vecs[3]  = '{"rd_rxdata_rst",  1'b1, 4'h0, 2'd1, 32'h0, 32'h0, 1'b0};
        vecs[4]  = '{"wr_ctrl_nosel",  1'b0, 4'he, 2'd3, 32'h3, 32'h0, 1'b0};
        vecs[5]  = '{"rd_ctrl_nosel",  1'b1, 4'h0, 2'd3, 32'h0, 32'h0, 1'b0};
        vecs[6]  = '{"wr_ctrl_txie",   1'b0, 4'h1, 2'd3, 32'h1, 32'h0, 1'b1};
        vecs[7]  = '{"rd_ctrl_txie",   1'b1, 4'h0, 2'd3, 32'h0, 32'h1, 1'b1};
        vecs[8]  = '{"wr_ctrl_rxie",   1'b0, 4'h1, 2'd3, 32'h2, 32'h0, 1'b0};
        vecs[9]  = '{"rd_ctrl_rxie",   1'b1, 4'h0, 2'd3, 32'h0, 32'h2, 1'b0};
        vecs[10] = '{"wr_ctrl_zero",   1'b0, 4'h1, 2'd3, 32'h0, 32'h0, 1'b0};
        vecs[11] = '{"rd_ctrl_zero",   1'b1, 4'h0, 2'd3, 32'h0, 32'h0, 1'b0};

        // Reset
        rst = 1'b1;
        tick(2);
        check("rst_txd", {31'd0, txd}, 32'h1);
        check("rst_int", {31'd0, irq}, 32'h0);
        check("rst_data_o", rdata, 32'h0);
        rst = 1'b0;
        tick(1);

        // Register table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_read) begin
                bus_read(vecs[i].idx, got);
                check(vecs[i].name, got, vecs[i].exp_rdata);
            end else begin
                bus_write(vecs[i].idx, vecs[i].wdata, vecs[i].sel);
            end
            tick(1);
            check({vecs[i].name, "_int"}, {31'd0, irq}, {31'd0, vecs[i].exp_int});
        end

        // data_o gating by ce and we
        bus_write(2'd3, 32'h3, 4'h1);
        ce = 1'b1; we = 1'b1; addr = 32'hC; sel = 4'h0;
        #1 check("data_o_we", rdata, 32'h0);
        ce = 1'b0; we = 1'b0;
        #1 check("data_o_noce", rdata, 32'h0);
        bus_write(2'd3, 32'h0, 4'h1);
        tick(2);

        // TX frame of 0xA5; the second write lands while busy and must be ignored
        bus_write(2'd0, 32'h0000_00A5, 4'h1);
        bus_write(2'd0, 32'h0000_003C, 4'h1);
        tick(DIV / 2 - 1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 10; j++) begin
            check($sformatf("tx_bit%0d", j), {31'd0, txd}, {31'd0, frame[j]});
            if (j < 9) tick(DIV);
        end
        tick(DIV / 2 - 1);
        peek(2'd2, got);
        check("tx_busy_last", got, 32'h1);
        tick(1);
        peek(2'd2, got);
        check("tx_busy_drop", got, 32'h0);
        check("tx_idle_line", {31'd0, txd}, 32'h1);

        // Back-to-back write accepted as soon as busy drops, then reset mid-frame
        bus_write(2'd0, 32'h0000_0000, 4'h1);
        peek(2'd2, got);
        check("tx_b2b_busy", got, 32'h1);
        tick(30);
        check("tx_mid_low", {31'd0, txd}, 32'h0);
        rst = 1'b1;
        tick(1);
        check("rst_mid_txd", {31'd0, txd}, 32'h1);
        rst = 1'b0;
        peek(2'd2, got);
        check("rst_mid_status", got, 32'h0);
        tick(2);

        // RX of 0x5A with rx interrupt
        bus_write(2'd3, 32'h2, 4'h1);
        send_byte(8'h5A, 1'b1, DIV);
        tick(2);
        check("rx_int_set", {31'd0, irq}, 32'h1);
        bus_read(2'd1, got);
        check("rx_5a", got, 32'h0000_005A);
        check("rx_int_hold", {31'd0, irq}, 32'h1);
        tick(1);
        check("rx_int_clr", {31'd0, irq}, 32'h0);

        // Overrun
        send_byte(8'h11, 1'b1, DIV);
        send_byte(8'h22, 1'b1, DIV);
        tick(20);
        peek(2'd2, got);
        check("ovr_status", got, 32'h6);
        bus_write(2'd2, 32'h4, 4'h1);
        peek(2'd2, got);
        check("ovr_w1c", got, 32'h2);
        bus_read(2'd1, got);
        check("ovr_byte", got, 32'h0000_0011);
        peek(2'd2, got);
        check("ovr_empty", got, 32'h0);

        // Framing error: stop bit low past its mid-point, then line released
        send_byte(8'h33, 1'b0, 12);
        tick(30);
        peek(2'd2, got);
        check("ferr_status", got, 32'hA);
        bus_read(2'd1, got);
        check("ferr_byte", got, 32'h0000_0033);
        bus_write(2'd2, 32'h8, 4'h1);
        peek(2'd2, got);
        check("ferr_w1c", got, 32'h0);

        // False start glitch, then a clean byte proves the receiver recovered
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(40);
        peek(2'd2, got);
        check("glitch_status", got, 32'h0);
        send_byte(8'h96, 1'b1, DIV);
        tick(4);
        bus_read(2'd1, got);
        check("after_glitch", got, 32'h0000_0096);

        // RXDATA read in the same cycle a new byte is delivered
        send_byte(8'h5C, 1'b1, DIV);
        tick(4);
        fork
            send_byte(8'h77, 1'b1, DIV);
            begin
                tick(155);
                bus_read(2'd1, got_fork);
            end
        join
        check("same_cyc_old", got_fork, 32'h0000_005C);
        tick(4);
        peek(2'd2, got);
        check("same_cyc_status", got, 32'h2);
        bus_read(2'd1, got);
        check("same_cyc_new", got, 32'h0000_0077);

`ifdef UART_LOOPBACK_EN
        bus_write(2'd3, 32'h4, 4'h1);
        bus_write(2'd0, 32'h0000_00C3, 4'h1);
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            if (txd == 1'b0) lows++;
            tick(1);
        end
        check("lb_txd_idle", 32'(lows), 32'h0);
        bus_read(2'd1, got);
        check("lb_rxdata", got, 32'h0000_00C3);
`else
        lows = 0;
        bus_write(2'd3, 32'h4, 4'h1);
        bus_read(2'd3, got);
        check("ctrl_bit2_absent", got, 32'h0);
        bus_write(2'd0, 32'h0000_00C3, 4'h1);
        for (int k = 0; k < 200; k++) begin
            if (txd == 1'b0) lows++;
            tick(1);
        end
        check("nolb_txd_active", 32'(lows > 0), 32'h1);
        peek(2'd2, got);
        check("nolb_no_rx", got, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_lite.md
Name: uart_lite

Overview:
Memory-mapped 8N1 UART peripheral attached to the CPU data-bus port, in parallel with data_ram. The top-level address decoder asserts its ce.
- Consumes CPU load/store transactions.
- Drives a level interrupt, uart_int_o, into bit 0 of the CPU's 6-bit interrupt vector.
- Single-byte TX shifter and single-byte RX holding register; no FIFOs.

Parameters:
CLK_DIV, 434, clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  synchronous, active-high reset.
ce_i  input  1  bus select from top-level decoder.
we_i  input  1  1 = write, 0 = read.
addr_i  input  32  byte address; only addr_i[3:2] decoded.
sel_i  input  4  byte enables; sel_i[0] qualifies data_i[7:0].
data_i  input  32  write data.
data_o  output  32  read data, combinational.
uart_int_o  output  1  level interrupt.
txd_o  output  1  serial out, idle high.
rxd_i  input  1  serial in, asynchronous.

Behaviour:
Clocking and reset (already decided): one clock, clk; reset rst is synchronous, active-high. Reset values:
- txd_o=1, uart_int_o=0, data_o=0.
- All registers 0; both FSMs IDLE.
- rxd synchronizer flops = 1.
Reset mid-frame aborts TX/RX immediately, with txd_o=1 on the next cycle.

Register map (addr_i[3:2]). Writes act only when ce_i & we_i & sel_i[0]; reads return zero-extended values.
- 0 TXDATA: W starts TX of data_i[7:0] if TX idle; a write while busy is ignored. R returns 0.
- 1 RXDATA: R returns {24'b0, rx_byte}. A read (ce_i & ~we_i) clears rx_valid at the clock edge.
- 2 STATUS: [0] tx_busy, [1] rx_valid, [2] rx_overrun, [3] frame_err. W1C on bits 2–3; bits 0–1 read-only.
- 3 CTRL: [0] tx_int_en, [1] rx_int_en; R/W.
- data_o = 0 when ce_i=0 or we_i=1.

Interrupt: uart_int_o is registered = (rx_int_en & rx_valid) | (tx_int_en & ~tx_busy). One cycle of latency from its sources.

TX FSM (IDLE, START, DATA, STOP); each state lasts CLK_DIV cycles, counted by a bit counter.
- IDLE → START on an accepted TXDATA write; txd_o=0 from the next cycle.
- DATA: 8 bits, LSB first.
- STOP: txd_o=1.
- tx_busy=1 from the cycle after the write until the end of STOP.
- Frame length is 10*CLK_DIV cycles. A back-to-back write is accepted the cycle tx_busy drops.

RX path:
- rxd_i passes through a 2-flop synchronizer.
- FSM states: IDLE, START, DATA, STOP.
- IDLE → START on the synchronized line reading 0.
- START: after CLK_DIV/2 cycles, resample. If 1 (false start), return to IDLE; else go to DATA.
- DATA: sample each bit CLK_DIV cycles apart, LSB first.
- STOP: sample at mid-bit. If 0, set frame_err; the byte is still delivered.
- Delivery in the cycle after the stop sample:
  - rx_valid=0: load rx_byte, set rx_valid.
  - rx_valid=1: keep old rx_byte, set rx_overrun, discard new byte.
  - Same-cycle RXDATA read: new byte loads, rx_valid stays 1, no overrun.
- Same-cycle W1C and a new error event: the set wins.

Optional Feature:
UART_LOOPBACK_EN
- Defined: CTRL[2] = loopback. When 1, the RX input is the internal TX serial signal and txd_o is held 1.
- Undefined: CTRL[2] is not implemented, reads 0, and writes are ignored.

Decomposition:
Shared defines file (alongside the existing CPU defines):
- register offsets UART_TXDATA..UART_CTRL;
- STATUS/CTRL bit positions;
- FSM state encodings UART_S_IDLE/START/DATA/STOP (2-bit);
- UART_IDLE_LEVEL.

One sub-module, uart_rx: synchronizer, RX FSM, sample counter. Outputs a byte_valid pulse, byte, and frame error. TX, registers and bus decode live in uart_lite.

Test Plan:
All cases use CLK_DIV=16.
1. Reset: hold rst 2 cycles → txd_o=1, uart_int_o=0, STATUS=0x0, CTRL=0x0.
2. TX timing: write TXDATA=0x000000A5, sel=4'b0001 → txd_o low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high. STATUS[0]=1 for 160 cycles. A second write 0x3C while busy is ignored.
3. RX: drive 0x5A 8N1 on rxd_i with CTRL=0x2 → uart_int_o=1; RXDATA reads 0x0000005A; uart_int_o=0 two cycles after the read.
4. Overrun: send 0x11 then 0x22 without reading → RXDATA=0x11, STATUS=0x6. Write STATUS=0x4 → STATUS=0x2.
5. Framing and false start: send 0x33 with stop bit 0 → rx_byte=0x33, STATUS[3]=1. A 4-cycle low glitch → no byte, FSM back to IDLE.
6. Loopback (UART_LOOPBACK_EN): CTRL=0x4, write TXDATA=0xC3 → txd_o stays 1; RXDATA=0xC3 after about 160 cycles.
